// File: rtl/t5_exec.sv
// ---------------------------------------------------------------------------
// t5_exec -- execute stage of the tra5 RV32I pipeline
//
// Sits directly behind the decode stage. Takes the registered decode operands,
// the opcode fields and the instruction PC. It produces the ALU result,
// the load/store address and store data, the branch decision, and the
// jump/branch target and link value. Every result is registered for the
// memory stage.
//
// Configuration macro: T5_MUL_EN
//   defined   : OP instructions with funct7 = 0000001 and funct3 0xx run an
//               iterative radix-2 multiplier. xstall holds upstream while it
//               runs. funct3 1xx (div/rem) is flagged as unsupported.
//   undefined : there is no multiplier and xstall is tied low. Every M-extension
//               op is flagged as unsupported, with 1-cycle latency.
//
// Ports
//   sclk    in   clock; all state changes on the rising edge
//   srst    in   synchronous reset, active-high
//   sena    in   pipeline enable; the stage advances on sena & !xstall
//   dop1    in   operand 1 (rs1, or PC for AUIPC/LUI/JAL/BRANCH)
//   dop2    in   operand 2 (rs2 for OP, otherwise the immediate)
//   dcp1    in   rs1 value for the branch compare
//   dcp2    in   rs2 value for the branch compare and the store data
//   dopc    in   opcode bits [6:2]
//   dfn3    in   funct3 bits [14:12]
//   dfn7    in   funct7 bits [31:25]
//   xpc     in   PC of this instruction; bits [1:0] carry the hart id
//   xres    out  ALU result or link value
//   xadr    out  load/store effective address
//   xsdt    out  store data
//   xtgt    out  branch/jump target; bits [1:0] come from xpc
//   xbra    out  control transfer taken
//   xopc    out  opcode, passed down the pipe
//   xfn3    out  funct3, passed down the pipe
//   xwbe    out  result is written back to rd
//   xill    out  unsupported instruction
//   xstall  out  stage busy, combinational; upstream must hold its outputs
// ---------------------------------------------------------------------------
module t5_exec #(
    parameter int XLEN = 32
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic            sena,
    input  logic [XLEN-1:0] dop1,
    input  logic [XLEN-1:0] dop2,
    input  logic [XLEN-1:0] dcp1,
    input  logic [XLEN-1:0] dcp2,
    input  logic [6:2]      dopc,
    input  logic [14:12]    dfn3,
    input  logic [31:25]    dfn7,
    input  logic [XLEN-1:0] xpc,
    output logic [XLEN-1:0] xres,
    output logic [XLEN-1:0] xadr,
    output logic [XLEN-1:0] xsdt,
    output logic [XLEN-1:0] xtgt,
    output logic            xbra,
    output logic [6:2]      xopc,
    output logic [14:12]    xfn3,
    output logic            xwbe,
    output logic            xill,
    output logic            xstall
);

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_RESET  = 5'h0D;

    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] alu;
    logic            sub;
    logic            take;
    logic            mext;
    logic            adv;

    logic [XLEN-1:0] n_res;
    logic            n_wbe;
    logic            n_bra;
    logic            n_ill;

    // One adder serves address generation, AUIPC and all targets.
    assign sum  = dop1 + dop2;

    // The link value steps only the word address, so the hart id in [1:0] is kept.
    assign link = {xpc[XLEN-1:2] + {(XLEN-2){1'b0}} + 1'b1, xpc[1:0]};

    // For JALR, clearing bit 0 and then forcing [1:0] from xpc gives the same
    // value as JAL/BRANCH. One target expression therefore covers all three.
    assign tgt  = {sum[XLEN-1:2], xpc[1:0]};

    assign sub  = (dopc == OPC_OP) & dfn7[30];
    assign mext = (dopc == OPC_OP) & (dfn7 == 7'b0000001);

    always_comb begin
        alu = '0;
        case (dfn3)
            3'b000: alu = sub ? (dop1 - dop2) : (dop1 + dop2);
            3'b001: alu = dop1 << dop2[4:0];
            3'b010: alu = {{(XLEN-1){1'b0}}, ($signed(dop1) < $signed(dop2))};
            3'b011: alu = {{(XLEN-1){1'b0}}, (dop1 < dop2)};
            3'b100: alu = dop1 ^ dop2;
            3'b101: begin
                if (dfn7[30]) begin
                    alu = $signed(dop1) >>> dop2[4:0];
                end else begin
                    alu = dop1 >> dop2[4:0];
                end
            end
            3'b110: alu = dop1 | dop2;
            3'b111: alu = dop1 & dop2;
            default: alu = '0;
        endcase
    end

    always_comb begin
        take = 1'b0;
        case (dfn3)
            3'b000:  take = (dcp1 == dcp2);
            3'b001:  take = (dcp1 != dcp2);
            3'b100:  take = ($signed(dcp1) <  $signed(dcp2));
            3'b101:  take = ($signed(dcp1) >= $signed(dcp2));
            3'b110:  take = (dcp1 <  dcp2);
            3'b111:  take = (dcp1 >= dcp2);
            default: take = 1'b0;
        endcase
    end

`ifdef T5_MUL_EN
    localparam logic [1:0] MUL_IDLE = 2'd0;
    localparam logic [1:0] MUL_BUSY = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;

    logic [1:0]  mstate;
    logic [4:0]  mcnt;
    logic [63:0] mprod;
    logic [31:0] mcand;
    logic        mneg;

    logic        mulop;
    logic        asgn;
    logic        bsgn;
    logic        aneg;
    logic        bneg;
    logic [31:0] amag;
    logic [31:0] bmag;
    logic [32:0] mstep;
    logic [63:0] mfix;
    logic [31:0] mul_res;

    assign mulop = mext & ~dfn3[14];

    // MULH treats both operands as signed and MULHSU only rs1. MUL and MULHU
    // are unsigned; for MUL the low word is the same either way.
    assign asgn = (dfn3[13:12] == 2'b01) | (dfn3[13:12] == 2'b10);
    assign bsgn = (dfn3[13:12] == 2'b01);
    assign aneg = asgn & dop1[31];
    assign bneg = bsgn & dop2[31];
    assign amag = aneg ? (32'd0 - dop1) : dop1;
    assign bmag = bneg ? (32'd0 - dop2) : dop2;

    // Shift-right multiply. The multiplier sits in the low half of mprod. Each
    // step conditionally adds the multiplicand into the high half, then shifts
    // the whole product right by one.
    assign mstep   = {1'b0, mprod[63:32]} + (mprod[0] ? {1'b0, mcand} : 33'd0);
    assign mfix    = mneg ? (64'd0 - mprod) : mprod;
    assign mul_res = (dfn3[13:12] == 2'b00) ? mfix[31:0] : mfix[63:32];

    // Reset drops the stall immediately so the pipe can restart cleanly.
    assign xstall = mulop & (mstate != MUL_DONE) & ~srst;

    always_ff @(posedge sclk) begin
        if (srst) begin
            mstate <= MUL_IDLE;
            mcnt   <= 5'd0;
            mprod  <= 64'd0;
            mcand  <= 32'd0;
            mneg   <= 1'b0;
        end else begin
            case (mstate)
                MUL_IDLE: begin
                    if (mulop & sena) begin
                        mprod  <= {32'd0, bmag};
                        mcand  <= amag;
                        mneg   <= aneg ^ bneg;
                        mcnt   <= 5'd0;
                        mstate <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    mprod <= {mstep, mprod[31:1]};
                    mcnt  <= mcnt + 5'd1;
                    if (mcnt == 5'd31) begin
                        mstate <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    // The output registers take the result on this same enabled edge.
                    if (sena) begin
                        mstate <= MUL_IDLE;
                    end
                end
                default: mstate <= MUL_IDLE;
            endcase
        end
    end
`else
    assign xstall = 1'b0;
`endif

    always_comb begin
        n_res = '0;
        n_wbe = 1'b0;
        n_bra = 1'b0;
        n_ill = 1'b0;
        case (dopc)
            OPC_OPIMM: begin
                n_res = alu;
                n_wbe = 1'b1;
            end
            OPC_OP: begin
                if (mext) begin
`ifdef T5_MUL_EN
                    if (dfn3[14]) begin
                        n_ill = 1'b1;
                    end else begin
                        n_res = mul_res;
                        n_wbe = 1'b1;
                    end
`else
                    n_ill = 1'b1;
`endif
                end else begin
                    n_res = alu;
                    n_wbe = 1'b1;
                end
            end
            OPC_LUI: begin
                n_res = dop2;
                n_wbe = 1'b1;
            end
            OPC_AUIPC: begin
                n_res = sum;
                n_wbe = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                n_res = link;
                n_bra = 1'b1;
                n_wbe = 1'b1;
            end
            OPC_BRANCH: begin
                n_bra = take;
            end
            OPC_LOAD: begin
                n_wbe = 1'b1;
            end
            default: begin
                n_res = '0;
            end
        endcase
    end

    assign adv = sena & ~xstall;

    // Address, store data and target are registered for every opcode.
    // The memory stage uses them only where the opcode gives them meaning.
    always_ff @(posedge sclk) begin
        if (srst) begin
            xres <= '0;
            xadr <= '0;
            xsdt <= '0;
            xtgt <= '0;
            xbra <= 1'b0;
            xopc <= OPC_RESET;
            xfn3 <= 3'b000;
            xwbe <= 1'b0;
            xill <= 1'b0;
        end else if (adv) begin
            xres <= n_res;
            xadr <= sum;
            xsdt <= dcp2;
            xtgt <= tgt;
            xbra <= n_bra;
            xopc <= dopc;
            xfn3 <= dfn3;
            xwbe <= n_wbe;
            xill <= n_ill;
        end
    end

endmodule

// File: tb/tb_t5_exec.sv
// ---------------------------------------------------------------------------
// tb_t5_exec -- self-checking bench for t5_exec
//
// A behavioural reference computes each instruction's outputs from the
// RV32I rules. A compare process checks the DUT against it on every falling
// edge. Directed cases pin the reference with hand-computed literals.
// Randomized instructions follow. When T5_MUL_EN is defined, multiplier
// latency and reset-during-multiply cases are exercised too.
// ---------------------------------------------------------------------------
module tb_t5_exec;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] adr;
        logic [31:0] sdt;
        logic [31:0] tgt;
        logic        bra;
        logic        wbe;
        logic        ill;
        logic [4:0]  opc;
        logic [2:0]  fn3;
    } out_t;

    logic        sclk;
    logic        srst;
    logic        sena;
    logic [31:0] dop1;
    logic [31:0] dop2;
    logic [31:0] dcp1;
    logic [31:0] dcp2;
    logic [4:0]  dopc;
    logic [2:0]  dfn3;
    logic [6:0]  dfn7;
    logic [31:0] xpc;
    logic [31:0] xres;
    logic [31:0] xadr;
    logic [31:0] xsdt;
    logic [31:0] xtgt;
    logic        xbra;
    logic [4:0]  xopc;
    logic [2:0]  xfn3;
    logic        xwbe;
    logic        xill;
    logic        xstall;

    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;
    out_t expv;
    int   k = 0;

    t5_exec dut (
        .sclk   (sclk),
        .srst   (srst),
        .sena   (sena),
        .dop1   (dop1),
        .dop2   (dop2),
        .dcp1   (dcp1),
        .dcp2   (dcp2),
        .dopc   (dopc),
        .dfn3   (dfn3),
        .dfn7   (dfn7),
        .xpc    (xpc),
        .xres   (xres),
        .xadr   (xadr),
        .xsdt   (xsdt),
        .xtgt   (xtgt),
        .xbra   (xbra),
        .xopc   (xopc),
        .xfn3   (xfn3),
        .xwbe   (xwbe),
        .xill   (xill),
        .xstall (xstall)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    function automatic out_t reset_out();
        out_t o;
        o     = '0;
        o.opc = 5'h0D;
        return o;
    endfunction

    function automatic logic is_mul(input logic [4:0] opc, input logic [2:0] fn3,
                                    input logic [6:0] fn7);
`ifdef T5_MUL_EN
        return (opc == 5'b01100) && (fn7 == 7'h01) && !fn3[2];
`else
        return 1'b0;
`endif
    endfunction

    function automatic out_t ref_exec(input logic [4:0] opc, input logic [2:0] fn3,
                                      input logic [6:0] fn7, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] c1,
                                      input logic [31:0] c2, input logic [31:0] pc);
        out_t        o;
        logic [31:0] s;
        logic [31:0] t;
        logic [63:0] p;
        o     = '0;
        o.opc = opc;
        o.fn3 = fn3;
        s     = a + b;
        o.adr = s;
        o.sdt = c2;
        t      = s;
        t[1:0] = pc[1:0];
        o.tgt  = t;
        p      = 64'd0;
        case (opc)
            5'b00100, 5'b01100: begin
                if (opc == 5'b01100 && fn7 == 7'h01) begin
`ifdef T5_MUL_EN
                    if (fn3[2]) begin
                        o.ill = 1'b1;
                    end else begin
                        o.wbe = 1'b1;
                        case (fn3[1:0])
                            2'd0: p = {32'd0, a} * {32'd0, b};
                            2'd1: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                            2'd2: p = {{32{a[31]}}, a} * {32'd0, b};
                            default: p = {32'd0, a} * {32'd0, b};
                        endcase
                        o.res = (fn3[1:0] == 2'd0) ? p[31:0] : p[63:32];
                    end
`else
                    o.ill = 1'b1;
`endif
                end else begin
                    o.wbe = 1'b1;
                    case (fn3)
                        3'd0: o.res = (opc == 5'b01100 && fn7[5]) ? a - b : a + b;
                        3'd1: o.res = a << b[4:0];
                        3'd2: o.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        3'd3: o.res = (a < b) ? 32'd1 : 32'd0;
                        3'd4: o.res = a ^ b;
                        3'd5: begin
                            if (fn7[5]) o.res = $signed(a) >>> b[4:0];
                            else        o.res = a >> b[4:0];
                        end
                        3'd6: o.res = a | b;
                        default: o.res = a & b;
                    endcase
                end
            end
            5'b01101: begin o.res = b; o.wbe = 1'b1; end
            5'b00101: begin o.res = s; o.wbe = 1'b1; end
            5'b11011: begin
                o.res = ((pc & ~32'h3) + 32'd4) | (pc & 32'h3);
                o.bra = 1'b1;
                o.wbe = 1'b1;
            end
            5'b11001: begin
                t      = s & ~32'h1;
                t[1:0] = pc[1:0];
                o.tgt  = t;
                o.res  = ((pc & ~32'h3) + 32'd4) | (pc & 32'h3);
                o.bra  = 1'b1;
                o.wbe  = 1'b1;
            end
            5'b11000: begin
                case (fn3)
                    3'd0: o.bra = (c1 == c2);
                    3'd1: o.bra = (c1 != c2);
                    3'd4: o.bra = ($signed(c1) <  $signed(c2));
                    3'd5: o.bra = ($signed(c1) >= $signed(c2));
                    3'd6: o.bra = (c1 <  c2);
                    3'd7: o.bra = (c1 >= c2);
                    default: o.bra = 1'b0;
                endcase
            end
            5'b00000: o.wbe = 1'b1;
            default: o.res = 32'd0;
        endcase
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference pipeline register. Any multiply is tracked as a count of stall cycles.
    always @(posedge sclk) begin
        if (srst) begin
            expv = reset_out();
            k    = 0;
        end else if (is_mul(dopc, dfn3, dfn7)) begin
            if (k == 33) begin
                if (sena) begin
                    expv = ref_exec(dopc, dfn3, dfn7, dop1, dop2, dcp1, dcp2, xpc);
                    k    = 0;
                end
            end else if (k == 0) begin
                if (sena) k = 1;
            end else begin
                k = k + 1;
            end
        end else if (sena) begin
            expv = ref_exec(dopc, dfn3, dfn7, dop1, dop2, dcp1, dcp2, xpc);
        end
    end

    always @(negedge sclk) begin : compare
        logic es;
        if (chk_en) begin
            es = is_mul(dopc, dfn3, dfn7) && (k < 33) && !srst;
            checkOutput("xstall", {31'd0, xstall}, {31'd0, es});
            checkOutput("xopc", {27'd0, xopc}, {27'd0, expv.opc});
            checkOutput("xfn3", {29'd0, xfn3}, {29'd0, expv.fn3});
            checkOutput("xres", xres, expv.res);
            checkOutput("xwbe", {31'd0, xwbe}, {31'd0, expv.wbe});
            checkOutput("xbra", {31'd0, xbra}, {31'd0, expv.bra});
            checkOutput("xill", {31'd0, xill}, {31'd0, expv.ill});
            if (expv.opc == 5'b00000 || expv.opc == 5'b01000)
                checkOutput("xadr", xadr, expv.adr);
            if (expv.opc == 5'b01000)
                checkOutput("xsdt", xsdt, expv.sdt);
            if (expv.opc == 5'b11000 || expv.opc == 5'b11001 || expv.opc == 5'b11011)
                checkOutput("xtgt", xtgt, expv.tgt);
        end
    end

    // Drive one instruction and return just after the edge that registers it.
    task automatic applyStimulus(input logic [4:0] opc, input logic [2:0] fn3,
                                 input logic [6:0] fn7, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] c1,
                                 input logic [31:0] c2, input logic [31:0] pc,
                                 input logic en);
        dopc = opc;
        dfn3 = fn3;
        dfn7 = fn7;
        dop1 = a;
        dop2 = b;
        dcp1 = c1;
        dcp2 = c2;
        xpc  = pc;
        sena = en;
        @(posedge sclk);
        #1;
    endtask

`ifdef T5_MUL_EN
    task automatic runMul(input logic [2:0] fn3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input string name);
        int stalls;
        stalls = 0;
        dopc = 5'b01100;
        dfn3 = fn3;
        dfn7 = 7'h01;
        dop1 = a;
        dop2 = b;
        dcp1 = 32'd0;
        dcp2 = 32'd0;
        xpc  = 32'h400;
        sena = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge sclk);
            if (xstall) stalls++;
            else break;
        end
        checkOutput({name, "_stalls"}, stalls, 33);
        @(posedge sclk);
        #1;
        checkOutput(name, xres, exp);
    endtask
`endif

    initial begin
        logic [4:0]  opcs [9];
        logic [4:0]  ro;
        logic [6:0]  rf7;
        logic [31:0] ra;
        logic [31:0] rc1;
        logic [31:0] rc2;
        out_t        mref;

        opcs = '{5'b00100, 5'b01100, 5'b01101, 5'b00101, 5'b11011,
                 5'b11001, 5'b11000, 5'b00000, 5'b01000};

        srst = 1'b1;
        sena = 1'b0;
        dop1 = '0; dop2 = '0; dcp1 = '0; dcp2 = '0;
        dopc = '0; dfn3 = '0; dfn7 = '0; xpc = '0;
        repeat (3) @(posedge sclk);
        #1;
        chk_en = 1'b1;
        checkOutput("rst_xopc", {27'd0, xopc}, 32'h0D);
        checkOutput("rst_xres", xres, 32'd0);
        checkOutput("rst_xwbe", {31'd0, xwbe}, 32'd0);
        checkOutput("rst_xbra", {31'd0, xbra}, 32'd0);
        checkOutput("rst_xstall", {31'd0, xstall}, 32'd0);
        srst = 1'b0;

        applyStimulus(5'b01100, 3'd0, 7'h00, 32'd5, 32'd7, 0, 0, 32'h0, 1'b1);
        checkOutput("add", xres, 32'd12);
        checkOutput("add_wbe", {31'd0, xwbe}, 32'd1);
        applyStimulus(5'b01100, 3'd0, 7'h20, 32'd5, 32'd7, 0, 0, 32'h0, 1'b1);
        checkOutput("sub", xres, 32'hFFFFFFFE);
        applyStimulus(5'b00100, 3'd5, 7'h20, 32'h80000000, 32'd4, 0, 0, 32'h0, 1'b1);
        checkOutput("srai", xres, 32'hF8000000);
        applyStimulus(5'b00100, 3'd3, 7'h00, 32'd1, 32'hFFFFFFFF, 0, 0, 32'h0, 1'b1);
        checkOutput("sltiu", xres, 32'd1);
        applyStimulus(5'b11000, 3'd4, 7'h00, 32'h100, 32'h20, 32'hFFFFFFFF, 32'd1,
                      32'h102, 1'b1);
        checkOutput("blt_bra", {31'd0, xbra}, 32'd1);
        checkOutput("blt_tgt", xtgt, 32'h122);
        applyStimulus(5'b11000, 3'd6, 7'h00, 32'h100, 32'h20, 32'hFFFFFFFF, 32'd1,
                      32'h102, 1'b1);
        checkOutput("bltu_bra", {31'd0, xbra}, 32'd0);
        applyStimulus(5'b11001, 3'd0, 7'h00, 32'h1001, 32'd2, 0, 0, 32'h201, 1'b1);
        checkOutput("jalr_tgt", xtgt, 32'h1001);
        checkOutput("jalr_res", xres, 32'h205);
        checkOutput("jalr_bra", {31'd0, xbra}, 32'd1);
        applyStimulus(5'b01000, 3'd2, 7'h00, 32'h1000, 32'h10, 0, 32'hCAFE, 32'h0, 1'b1);
        checkOutput("sw_adr", xadr, 32'h1010);
        checkOutput("sw_sdt", xsdt, 32'hCAFE);
        applyStimulus(5'b00100, 3'd0, 7'h00, 32'd1, 32'd1, 0, 0, 32'h0, 1'b0);
        checkOutput("hold_res", xres, 32'h0);

`ifdef T5_MUL_EN
        runMul(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, "mulh");
        runMul(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, "mul");
        runMul(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
        runMul(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
        for (int n = 0; n < 4; n++) begin
            ra   = $urandom;
            rc1  = $urandom;
            mref = ref_exec(5'b01100, 3'(n), 7'h01, ra, rc1, 0, 0, 32'h400);
            runMul(3'(n), ra, rc1, mref.res, "mul_rand");
        end
        dopc = 5'b01100; dfn3 = 3'd1; dfn7 = 7'h01;
        dop1 = 32'h1234; dop2 = 32'h5678; sena = 1'b1;
        repeat (10) @(posedge sclk);
        #1;
        srst = 1'b1;
        dopc = 5'b01100; dfn3 = 3'd0; dfn7 = 7'h00; dop1 = 32'd5; dop2 = 32'd7;
        @(posedge sclk);
        #1;
        checkOutput("rst_busy_stall", {31'd0, xstall}, 32'd0);
        checkOutput("rst_busy_xopc", {27'd0, xopc}, 32'h0D);
        srst = 1'b0;
        @(posedge sclk);
        #1;
        checkOutput("add_after_rst", xres, 32'd12);
`else
        applyStimulus(5'b01100, 3'd0, 7'h01, 32'd3, 32'd4, 0, 0, 32'h0, 1'b1);
        checkOutput("mul_ill", {31'd0, xill}, 32'd1);
        checkOutput("mul_res", xres, 32'd0);
        checkOutput("mul_wbe", {31'd0, xwbe}, 32'd0);
`endif

        for (int n = 0; n < 400; n++) begin
            int idx;
            idx = $urandom_range(0, 9);
            ro  = (idx == 9) ? 5'($urandom) : opcs[idx];
            case ($urandom_range(0, 3))
                0: rf7 = 7'h00;
                1: rf7 = 7'h20;
                2: rf7 = 7'h01;
                default: rf7 = 7'($urandom);
            endcase
`ifdef T5_MUL_EN
            if (ro == 5'b01100 && rf7 == 7'h01) rf7 = 7'h00;
`endif
            ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            rc1 = $urandom;
            rc2 = ($urandom_range(0, 3) == 0) ? rc1 : $urandom;
            srst = ($urandom_range(0, 63) == 0);
            applyStimulus(ro, 3'($urandom), rf7, ra, $urandom, rc1, rc2, $urandom,
                          ($urandom_range(0, 4) != 0));
        end
        srst = 1'b0;
        @(negedge sclk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
